// File: rtl/imem_port_arbiter_pkg.sv
// Shared types for the instruction-memory debug-port arbiter: FSM states,
// requester id and the default post-write flush length.
package imem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    DRAIN  = 2'd3
  } arb_state_t;

  typedef logic req_id_t;

  localparam int FLUSH_CYC_DEF = 2;

endpackage

// File: rtl/imem_port_arbiter_rr_arb2.sv
// Two-requester arbiter with a one-hot grant. IMEM_ARB_RR_EN selects
// round-robin (pointer remembers the last winner); otherwise r0 has fixed priority.
module rr_arb2 (
`ifdef IMEM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef IMEM_ARB_RR_EN
  logic last_r1;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_r1 ? 2'b01 : 2'b10;
  end

  // Reset leaves "r1 granted last" so r0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_r1 <= 1'b1;
    else if (advance && (gnt != 2'b00)) last_r1 <= gnt[1];
  end
`else
  always_comb begin
    gnt = 2'b00;
    if (req[0]) gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`endif

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates two requesters onto the instruction RAM debug port and holds the
// CPU fetch stage while a write flushes. Optional macro: IMEM_ARB_RR_EN.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_we,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_we,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic [31:0] mem_A2,
  output logic [31:0] mem_WD2,
  output logic [3:0]  mem_WE2,
  input  logic [31:0] mem_RD2,
  output logic        cpu_hold
);

  localparam logic [3:0] CNT_LOAD = (FLUSH_CYC > 0) ? 4'(FLUSH_CYC - 1) : 4'd0;

  arb_state_t state;
  logic [3:0] cnt;
  req_id_t    cap_id;
  logic       idle;
  logic [1:0] arb_req;
  logic [1:0] arb_gnt;
  logic [3:0] sel_we;

  assign idle    = (state == IDLE) && !rst;
  assign arb_req = idle ? {r1_req, r0_req} : 2'b00;
  assign r0_gnt  = arb_gnt[0];
  assign r1_gnt  = arb_gnt[1];
  assign sel_we  = arb_gnt[1] ? r1_we : r0_we;

  rr_arb2 u_arb (
`ifdef IMEM_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
    .advance (idle),
`endif
    .req     (arb_req),
    .gnt     (arb_gnt)
  );

  assign r0_rdata = r0_rvalid ? mem_RD2 : 32'h0;
  assign r1_rdata = r1_rvalid ? mem_RD2 : 32'h0;

  // mem_* double as the captured payload: loaded on grant, cleared on ACCESS exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_id    <= 1'b0;
      mem_A2    <= 32'h0;
      mem_WD2   <= 32'h0;
      mem_WE2   <= 4'h0;
      cpu_hold  <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_gnt != 2'b00) begin
            state    <= ACCESS;
            cap_id   <= arb_gnt[1];
            mem_A2   <= arb_gnt[1] ? r1_addr : r0_addr;
            mem_WD2  <= arb_gnt[1] ? r1_wdata : r0_wdata;
            mem_WE2  <= sel_we;
            cpu_hold <= (sel_we != 4'h0);
          end
        end
        ACCESS: begin
          mem_A2  <= 32'h0;
          mem_WD2 <= 32'h0;
          mem_WE2 <= 4'h0;
          if (mem_WE2 == 4'h0) begin
            state     <= RESP;
            r0_rvalid <= (cap_id == 1'b0);
            r1_rvalid <= (cap_id == 1'b1);
          end else if (FLUSH_CYC == 0) begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
          end else begin
            state <= DRAIN;
            cnt   <= CNT_LOAD;
          end
        end
        RESP: begin
          state     <= IDLE;
          r0_rvalid <= 1'b0;
          r1_rvalid <= 1'b0;
        end
        DRAIN: begin
          if (cnt == 4'd0) begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter: directed stimulus pushes expected
// grants and read responses; a negedge monitor pops and compares them.
module tb_imem_port_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_req = 1'b0, r1_req = 1'b0;
  logic [31:0] r0_addr = '0, r1_addr = '0, r0_wdata = '0, r1_wdata = '0;
  logic [3:0]  r0_we = '0, r1_we = '0;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, cpu_hold;
  logic [31:0] r0_rdata, r1_rdata, mem_A2, mem_WD2, mem_RD2;
  logic [3:0]  mem_WE2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic ram_init = 1'b0;
  logic [31:0] ram [0:63];
  rsp_t rsp_q[$];
  logic gnt_q[$];

  imem_port_arbiter #(.FLUSH_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_we(r0_we),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_we(r1_we),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_A2(mem_A2), .mem_WD2(mem_WD2), .mem_WE2(mem_WE2), .mem_RD2(mem_RD2),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM model, one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      ram[4]   <= 32'hDEADBEEF;
      ram[5]   <= 32'h55AA55AA;
      ram[9]   <= 32'h11223344;
      ram[16]  <= 32'h01234567;
      ram_init <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_WE2[b]) ram[mem_A2[7:2]][8*b +: 8] <= mem_WD2[8*b +: 8];
    end
    mem_RD2 <= ram[mem_A2[7:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every grant and every read response must match the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (r0_gnt || r1_gnt) begin
        if (r0_gnt && r1_gnt) chk("gnt_onehot", {r1_gnt, r0_gnt}, 32'h1);
        if (gnt_q.size() == 0) chk("gnt_unexpected", {r1_gnt, r0_gnt}, 32'h0);
        else chk("gnt_id", r1_gnt, gnt_q.pop_front());
      end
      if (r0_rvalid || r1_rvalid) begin
        rsp_t e;
        if (rsp_q.size() == 0) chk("rvalid_unexpected", {r1_rvalid, r0_rvalid}, 32'h0);
        else begin
          e = rsp_q.pop_front();
          chk("rsp_port", {r1_rvalid, r0_rvalid}, e.id ? 32'h2 : 32'h1);
          chk("rsp_data", e.id ? r1_rdata : r0_rdata, e.data);
          chk("rsp_other_rdata", e.id ? r0_rdata : r1_rdata, 32'h0);
        end
      end
    end
  end

  task automatic drive(input int id, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
    if (id == 0) begin r0_addr = a; r0_wdata = wd; r0_we = we; r0_req = 1'b1; end
    else begin r1_addr = a; r1_wdata = wd; r1_we = we; r1_req = 1'b1; end
  endtask

  task automatic wait_gnt(input int id, output int gcyc);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((id == 0 && r0_gnt) || (id == 1 && r1_gnt)) got = 1;
    end
    gcyc = cyc;
    chk("gnt_wait", 32'(got), 32'h1);
    @(posedge clk); #1;
    if (id == 0) begin r0_req = 1'b0; r0_we = '0; r0_addr = '0; r0_wdata = '0; end
    else begin r1_req = 1'b0; r1_we = '0; r1_addr = '0; r1_wdata = '0; end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, t1, hold_n, we_n, prev;
    logic order [4];
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, hold_n, we_n, prev, gseen;
    logic order [4];
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {r1_gnt, r0_gnt}, 32'h0);
    chk("rst_rvalid", {r1_rvalid, r0_rvalid}, 32'h0);
    chk("rst_mem_A2", mem_A2, 32'h0);
    chk("rst_mem_WE2", mem_WE2, 32'h0);
    chk("rst_hold", cpu_hold, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    idle_cycles(1);

    // r0 read of 0x10: grant T, address T+1, data T+2.
    gnt_q.push_back(1'b0); rsp_q.push_back('{1'b0, 32'hDEADBEEF});
    drive(0, 32'h10, 32'h0, 4'h0);
    wait_gnt(0, t0);
    @(negedge clk);
    chk("rd_mem_A2", mem_A2, 32'h10);
    chk("rd_mem_WE2", mem_WE2, 32'h0);
    chk("rd_hold", cpu_hold, 32'h0);
    @(negedge clk);
    chk("rd_rvalid_T2", r0_rvalid, 32'h1);
    chk("rd_resp_A2", mem_A2, 32'h0);
    idle_cycles(2);

    // r0 read of 0x14; r1 pulses a request while busy and must be dropped.
    gnt_q.push_back(1'b0); rsp_q.push_back('{1'b0, 32'h55AA55AA});
    drive(0, 32'h14, 32'h0, 4'h0);
    wait_gnt(0, t0);
    drive(1, 32'h20, 32'hBAD0BAD0, 4'hF);
    @(posedge clk); #1 r1_req = 1'b0; r1_we = '0;
    idle_cycles(5);

    // r1 full-word write: one WE2 cycle, hold for 3 cycles, no rvalid.
    gnt_q.push_back(1'b1);
    drive(1, 32'h20, 32'h00000013, 4'hF);
    wait_gnt(1, t0);
    hold_n = 0; we_n = 0;
    @(negedge clk);
    chk("wr_mem_A2", mem_A2, 32'h20);
    chk("wr_mem_WD2", mem_WD2, 32'h13);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (cpu_hold) hold_n++;
      if (mem_WE2 == 4'hF) we_n++;
    end
    chk("wr_hold_cycles", 32'(hold_n), 32'd3);
    chk("wr_we_cycles", 32'(we_n), 32'd1);
    @(posedge clk); #1;

    // Partial write of the low half-word of 0x24, then read both words back.
    gnt_q.push_back(1'b1);
    drive(1, 32'h24, 32'hAABBCCDD, 4'h3);
    wait_gnt(1, t0);
    idle_cycles(4);
    gnt_q.push_back(1'b0); rsp_q.push_back('{1'b0, 32'h1122CCDD});
    drive(0, 32'h24, 32'h0, 4'h0);
    wait_gnt(0, t0);
    idle_cycles(2);
    gnt_q.push_back(1'b0); rsp_q.push_back('{1'b0, 32'h00000013});
    drive(0, 32'h20, 32'h0, 4'h0);
    wait_gnt(0, t0);
    idle_cycles(2);

    // r0 write then r1 read-after-write: r1 waits out ACCESS + two DRAIN cycles.
    gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
    rsp_q.push_back('{1'b1, 32'hCAFEF00D});
    drive(0, 32'h30, 32'hCAFEF00D, 4'hF);
    wait_gnt(0, t0);
    drive(1, 32'h30, 32'h0, 4'h0);
    wait_gnt(1, t1);
    chk("raw_gnt_gap", 32'(t1 - t0), 32'd4);
    idle_cycles(3);

    // Both requesters read continuously; last grant so far went to r1.
`ifdef IMEM_ARB_RR_EN
    order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int k = 0; k < 4; k++) begin
      gnt_q.push_back(order[k]);
      rsp_q.push_back('{order[k], order[k] ? 32'h01234567 : 32'hDEADBEEF});
    end
    drive(0, 32'h10, 32'h0, 4'h0);
    drive(1, 32'h40, 32'h0, 4'h0);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      gseen = 0;
      for (int i = 0; i < 10 && gseen == 0; i++) begin
        @(negedge clk);
        if (r0_gnt || r1_gnt) gseen = 1;
      end
      chk("cont_gnt_seen", 32'(gseen), 32'h1);
      if (k > 0) chk("cont_gnt_gap", 32'(cyc - prev), 32'd3);
      prev = cyc;
    end
    @(posedge clk); #1;
    r0_req = 1'b0; r1_req = 1'b0;
    idle_cycles(4);

    // Reset during RESP of an r1 read: the response is lost.
    gnt_q.push_back(1'b1);
    drive(1, 32'h10, 32'h0, 4'h0);
    wait_gnt(1, t0);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("abort_rvalid", r1_rvalid, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_cycles(3);

    // First tie after reset goes to r0, r1 follows three cycles later.
    gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
    rsp_q.push_back('{1'b0, 32'h55AA55AA}); rsp_q.push_back('{1'b1, 32'h01234567});
    drive(0, 32'h14, 32'h0, 4'h0);
    drive(1, 32'h40, 32'h0, 4'h0);
    wait_gnt(0, t0);
    wait_gnt(1, t1);
    chk("post_rst_gap", 32'(t1 - t0), 32'd3);
    idle_cycles(3);

    // Reset mid-write: cpu_hold and the write strobe clear asynchronously.
    gnt_q.push_back(1'b0);
    drive(0, 32'h50, 32'h00000077, 4'hF);
    wait_gnt(0, t0);
    @(negedge clk);
    chk("abort_hold_before", cpu_hold, 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_hold_async", cpu_hold, 32'h0);
    chk("abort_we_async", mem_WE2, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_cycles(2);
    gnt_q.push_back(1'b1); rsp_q.push_back('{1'b1, 32'h0});
    drive(1, 32'h50, 32'h0, 4'h0);
    wait_gnt(1, t0);
    idle_cycles(4);

    chk("rsp_q_empty", 32'(rsp_q.size()), 32'h0);
    chk("gnt_q_empty", 32'(gnt_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 Parameter FLUSH_CYC, default 2: extra cycles cpu_hold stays high after each write access (0..15).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 r0_req / r1_req  in  1  access request; held with its payload until the matching gnt.
REQ-005 r0_addr / r1_addr  in  32  byte address.
REQ-006 r0_wdata / r1_wdata  in  32  write data.
REQ-007 r0_we / r1_we  in  4  byte write enables; 0 = read.
REQ-008 r0_gnt / r1_gnt  out  1  one-cycle grant pulse; payload captured at that edge.
REQ-009 r0_rvalid / r1_rvalid  out  1  one-cycle read-data-valid pulse.
REQ-010 r0_rdata / r1_rdata  out  32  read data, valid only with rvalid.
REQ-011 mem_A2  out  32  debug-port address to the instruction RAM.
REQ-012 mem_WD2  out  32  debug-port write data.
REQ-013 mem_WE2  out  4  debug-port byte enables.
REQ-014 mem_RD2  in  32  debug-port read data; synchronous, one-cycle latency.
REQ-015 cpu_hold  out  1  forces the IF/ID register enable low while instruction memory is being rewritten.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP, DRAIN.
REQ-017 IDLE: with any req high, gnt is driven combinationally to exactly one winner; next state ACCESS; winner addr/wdata/we/id registered.
REQ-018 ACCESS: mem_A2/WD2/WE2 are driven from the captured payload for exactly one cycle; read -> RESP; write with FLUSH_CYC>0 -> DRAIN; write with FLUSH_CYC=0 -> IDLE.
REQ-019 RESP: rvalid of the captured requester is high for one cycle, rdata = mem_RD2; next state IDLE.
REQ-020 Read latency: gnt in cycle T, rvalid in cycle T+2; back-to-back reads are granted every 3 cycles.
REQ-021 DRAIN: a down-counter loaded with FLUSH_CYC-1 on ACCESS exit; leaves to IDLE when it reaches 0; no gnt is issued during DRAIN.
REQ-022 cpu_hold is high in ACCESS (write only) and in every DRAIN cycle; low otherwise.
REQ-023 Outside ACCESS, mem_WE2=0, mem_A2=0, mem_WD2=0; rdata of the non-responding port = 0.
REQ-024 Writes never produce rvalid.
REQ-025 A req deasserted before gnt is dropped without side effects.
REQ-026 Only one access is in flight; requests arriving in non-IDLE states wait.

Reset
REQ-027 rst forces IDLE, counter 0, captured payload 0, all outputs 0, priority pointer "r1 last granted".
REQ-028 rst mid-access aborts it: no rvalid follows, and cpu_hold drops immediately (asynchronously).

Configuration
REQ-029 Macro IMEM_ARB_RR_EN defined: round-robin; on simultaneous requests the requester not granted last wins; pointer updates on every gnt.
REQ-030 Macro IMEM_ARB_RR_EN undefined: fixed priority, r0 always wins; pointer logic absent.

Structure
REQ-031 Shared package holds the state enum, requester-id type (1 bit), and FLUSH_CYC default constant.
REQ-032 One sub-module, rr_arb2: two-request arbiter (req[1:0] in, one-hot gnt out, advance input), containing the pointer under IMEM_ARB_RR_EN.

Verification
REQ-033 r0 read addr 0x10, mem holds 0xDEADBEEF at word 4 -> r0_gnt T, mem_A2=0x10 at T+1, r0_rvalid with 0xDEADBEEF at T+2.
REQ-034 r1 write 0x00000013 to 0x20, we=0xF, FLUSH_CYC=2 -> mem_WE2=0xF one cycle; cpu_hold high 3 cycles; no rvalid.
REQ-035 r0 and r1 read continuously with RR enabled -> grants alternate r0,r1,r0,r1 every 3 cycles; RR disabled -> only r0 granted.
REQ-036 rst asserted during RESP of a r1 read -> r1_rvalid never pulses; after release, the first simultaneous request is granted to r0.
REQ-037 r0 write followed by a r1 read of the same address -> r1 read returns the written value; r1_gnt not before DRAIN exit.
